// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_arb_pkg
// Description : Shared constants and state type for the round-robin mux arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SRC_W   = 2;

    // Pointer starts on the last requester so requester 0 wins first after reset
    localparam logic [SRC_W-1:0] LAST_SRC_RST = 2'd3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mux4_sel.sv
`default_nettype none
// ============================================================================
// Module      : mux4_sel
// Description : Combinational 4:1 multiplexer, DATA_W bits, 2-bit select.
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_sel #(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] i_d0,
    input  logic [DATA_W-1:0] i_d1,
    input  logic [DATA_W-1:0] i_d2,
    input  logic [DATA_W-1:0] i_d3,
    input  logic [1:0]        i_sel,
    output logic [DATA_W-1:0] o_y
);

    always_comb begin
        o_y = i_d0;
        case (i_sel)
            2'd0:    o_y = i_d0;
            2'd1:    o_y = i_d1;
            2'd2:    o_y = i_d2;
            default: o_y = i_d3;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_arbiter
// Description : Round-robin arbiter driving a shared 4:1 mux into a registered
//               valid/ready output stage. Define MUX_RR_ARBITER_STATS_EN to
//               build the per-requester saturating grant counters.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [DATA_W-1:0]  req_data0,
    input  logic [DATA_W-1:0]  req_data1,
    input  logic [DATA_W-1:0]  req_data2,
    input  logic [DATA_W-1:0]  req_data3,
    output logic [NUM_REQ-1:0] gnt,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [SRC_W-1:0]   out_src,
    input  logic               out_ready,
    input  logic [1:0]         stat_sel,
    input  logic               stat_clr,
    output logic [CNT_W-1:0]   stat_cnt
);

    arb_state_t          r_state;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic [SRC_W-1:0]    r_out_src;
    logic [SRC_W-1:0]    r_last_src;

    logic                w_any_req;
    logic                w_capture;
    logic [SRC_W-1:0]    w_idx;
    logic [SRC_W-1:0]    w_win;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [DATA_W-1:0]   w_mux_y;

    assign w_any_req = |req;
    assign w_capture = (r_state == IDLE) || out_ready;

    // Walk from the farthest candidate to the nearest so the nearest wins
    always_comb begin
        w_win = r_last_src;
        w_idx = r_last_src;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = r_last_src + SRC_W'(k);
            if (req[w_idx]) begin
                w_win = w_idx;
            end
        end
    end

    assign w_gnt = (rst_n && w_capture && w_any_req) ? (NUM_REQ'(1) << w_win) : '0;

    mux4_sel #(
        .DATA_W (DATA_W)
    ) u_mux (
        .i_d0  (req_data0),
        .i_d1  (req_data1),
        .i_d2  (req_data2),
        .i_d3  (req_data3),
        .i_sel (w_win),
        .o_y   (w_mux_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_last_src  <= LAST_SRC_RST;
        end else if (w_capture) begin
            if (w_any_req) begin
                r_state     <= HOLD;
                r_out_valid <= 1'b1;
                r_out_data  <= w_mux_y;
                r_out_src   <= w_win;
                r_last_src  <= w_win;
            end else begin
                r_state     <= IDLE;
                r_out_valid <= 1'b0;
            end
        end
    end

    assign gnt       = w_gnt;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

`ifdef MUX_RR_ARBITER_STATS_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] w_cnt;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;

        // Clear outranks increment; counters stick at all-ones
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (stat_clr) begin
                r_cnt <= '0;
            end else if (w_gnt[gi] && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        assign w_cnt[gi] = r_cnt;
    end

    assign stat_cnt = w_cnt[stat_sel];
`else
    logic w_unused_stats;
    assign w_unused_stats = ^{stat_sel, stat_clr};
    assign stat_cnt       = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_rr_arbiter
// Description : Self-checking bench for mux_rr_arbiter: directed vector table,
//               reset/statistics sequences and a randomized reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_rr_arbiter;

    localparam int DATA_W  = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef MUX_RR_ARBITER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [3:0]        req;
        logic [DATA_W-1:0] d0, d1, d2, d3;
        logic              rdy;
        logic [3:0]        e_gnt;
        logic              e_valid;
        logic [DATA_W-1:0] e_data;
        logic [1:0]        e_src;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        req;
    logic [DATA_W-1:0] d0, d1, d2, d3;
    logic [3:0]        gnt;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_src;
    logic              out_ready;
    logic [1:0]        stat_sel;
    logic              stat_clr;
    logic [CNT_W-1:0]  stat_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: what the output register should hold
    bit                m_valid;
    logic [DATA_W-1:0] m_data;
    int                m_src;
    int                m_last;
    int                m_cnt [4];

    vec_t tbl [16];

    always #5 clk = ~clk;

    mux_rr_arbiter #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data0 (d0),
        .req_data1 (d1),
        .req_data2 (d2),
        .req_data3 (d3),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .stat_sel  (stat_sel),
        .stat_clr  (stat_clr),
        .stat_cnt  (stat_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] dsel(input int j);
        case (j)
            0:       return d0;
            1:       return d1;
            2:       return d2;
            default: return d3;
        endcase
    endfunction

    // Winner index under rotating priority, or -1 when nothing is granted
    function automatic int model_win();
        int j;
        if (m_valid && !out_ready) return -1;
        for (int k = 1; k <= 4; k++) begin
            j = (m_last + k) % 4;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_gnt();
        int w;
        w = model_win();
        if (w < 0) return 4'b0000;
        return 4'(1 << w);
    endfunction

    function automatic logic [CNT_W-1:0] model_stat();
        if (!STATS) return '0;
        return CNT_W'(m_cnt[stat_sel]);
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = 0;
        m_last  = 3;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic model_edge();
        int w;
        w = model_win();
        if (stat_clr) begin
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else if (w >= 0 && m_cnt[w] < CNT_MAX) begin
            m_cnt[w]++;
        end
        if (!m_valid || out_ready) begin
            if (w >= 0) begin
                m_valid = 1'b1;
                m_data  = dsel(w);
                m_src   = w;
                m_last  = w;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    // Inputs already driven at the falling edge; check grant, clock, check outputs
    task automatic cycle(input string tag);
        #1 chk({tag, "_gnt"}, gnt, model_gnt());
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, "_valid"}, out_valid, m_valid);
        if (m_valid) begin
            chk({tag, "_data"}, out_data, m_data);
            chk({tag, "_src"}, out_src, m_src);
        end
        chk({tag, "_stat"}, stat_cnt, model_stat());
        @(negedge clk);
    endtask

    task automatic apply(input vec_t v, input int i);
        req = v.req; d0 = v.d0; d1 = v.d1; d2 = v.d2; d3 = v.d3; out_ready = v.rdy;
        #1 chk($sformatf("vec%0d_gnt", i), gnt, v.e_gnt);
        @(posedge clk);
        model_edge();
        #1;
        chk($sformatf("vec%0d_valid", i), out_valid, v.e_valid);
        chk($sformatf("vec%0d_data", i), out_data, v.e_data);
        chk($sformatf("vec%0d_src", i), out_src, v.e_src);
        chk($sformatf("vec%0d_stat", i), stat_cnt, model_stat());
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        // req     d0    d1    d2    d3    rdy  gnt      vld   data  src
        tbl[0]  = '{4'b1111, 4'hA, 4'hB, 4'hD, 4'hE, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0};
        tbl[1]  = '{4'b1111, 4'hA, 4'hB, 4'hD, 4'hE, 1'b1, 4'b0010, 1'b1, 4'hB, 2'd1};
        tbl[2]  = '{4'b1111, 4'hA, 4'hB, 4'hD, 4'hE, 1'b1, 4'b0100, 1'b1, 4'hD, 2'd2};
        tbl[3]  = '{4'b1111, 4'hA, 4'hB, 4'hD, 4'hE, 1'b1, 4'b1000, 1'b1, 4'hE, 2'd3};
        tbl[4]  = '{4'b1111, 4'hA, 4'hB, 4'hD, 4'hE, 1'b1, 4'b0001, 1'b1, 4'hA, 2'd0};
        tbl[5]  = '{4'b0001, 4'h1, 4'h2, 4'h0, 4'h0, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
        tbl[6]  = '{4'b0010, 4'h1, 4'h2, 4'h0, 4'h0, 1'b0, 4'b0000, 1'b1, 4'h1, 2'd0};
        tbl[7]  = '{4'b0010, 4'h1, 4'h2, 4'h0, 4'h0, 1'b0, 4'b0000, 1'b1, 4'h1, 2'd0};
        tbl[8]  = '{4'b0010, 4'h1, 4'h2, 4'h0, 4'h0, 1'b0, 4'b0000, 1'b1, 4'h1, 2'd0};
        tbl[9]  = '{4'b0010, 4'h1, 4'h2, 4'h0, 4'h0, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1};
        tbl[10] = '{4'b0000, 4'h1, 4'h2, 4'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 4'h2, 2'd1};
        tbl[11] = '{4'b1001, 4'h1, 4'h0, 4'h0, 4'h4, 1'b1, 4'b1000, 1'b1, 4'h4, 2'd3};
        tbl[12] = '{4'b1001, 4'h1, 4'h0, 4'h0, 4'h4, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
        tbl[13] = '{4'b0000, 4'h1, 4'h0, 4'h0, 4'h4, 1'b0, 4'b0000, 1'b1, 4'h1, 2'd0};
        tbl[14] = '{4'b0000, 4'h1, 4'h0, 4'h0, 4'h4, 1'b1, 4'b0000, 1'b0, 4'h1, 2'd0};
        tbl[15] = '{4'b0000, 4'h1, 4'h0, 4'h0, 4'h4, 1'b0, 4'b0000, 1'b0, 4'h1, 2'd0};

        rst_n = 1'b0; req = 4'b1111; out_ready = 1'b1;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        stat_sel = 2'd0; stat_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 4'h0);
        chk("rst_src", out_src, 2'd0);
        chk("rst_stat", stat_cnt, '0);
        model_reset();
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) apply(tbl[i], i);

        // Reset while a word is held discards it at once
        do_reset();
        req = 4'b0001; d0 = 4'h7; out_ready = 1'b0;
        cycle("hold7");
        chk("pre_rst_data", out_data, 4'h7);
        req = 4'b1111; rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_data", out_data, 4'h0);
        chk("midrst_gnt", gnt, 4'b0000);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; d0 = 4'h3; d1 = 4'h5; d2 = 4'h6; d3 = 4'h9; out_ready = 1'b1;
        #1 chk("post_rst_gnt", gnt, 4'b0001);
        @(posedge clk);
        model_edge();
        #1;
        chk("post_rst_src", out_src, 2'd0);
        chk("post_rst_data", out_data, 4'h3);
        @(negedge clk);

        for (int n = 0; n < 400; n++) begin
            req       = 4'($urandom_range(0, 15));
            d0        = 4'($urandom); d1 = 4'($urandom);
            d2        = 4'($urandom); d3 = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            stat_sel  = 2'($urandom_range(0, 3));
            stat_clr  = ($urandom_range(0, 31) == 0);
            cycle("rand");
        end

        // Saturation: 300 grants to requester 2
        stat_clr = 1'b1; req = 4'b0000; out_ready = 1'b1;
        cycle("clr0");
        stat_clr = 1'b0; req = 4'b0100; d2 = 4'h6; stat_sel = 2'd2;
        for (int n = 0; n < 300; n++) cycle("sat");
        chk("stat_saturated", stat_cnt, STATS ? 32'd255 : 32'd0);
        stat_clr = 1'b1; req = 4'b0000;
        cycle("clr1");
        chk("stat_cleared", stat_cnt, 32'd0);
        stat_clr = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares one 4:1, DATA_W-bit multiplexer datapath between four requesters. It sequences the mux select from a fair rotating priority, captures the selected word into a registered output stage and hands it downstream over a valid/ready handshake. It sits in front of the lab mux datapath and replaces the manually driven select input.

## Interface

Parameters:
- DATA_W, 4, width of each requester word and of the output word.
- CNT_W, 8, width of each per-requester grant counter (statistics build only).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  4  request lines; bit i belongs to requester i.
- req_data0..req_data3  in  DATA_W each  words offered by requesters 0..3, stable while the matching req bit is high.
- gnt  out  4  one-hot grant, combinational; req[i] & gnt[i] marks the transfer of req_data_i at that edge.
- out_valid  out  1  output register holds an unconsumed word.
- out_data  out  DATA_W  captured word.
- out_src  out  2  index of the requester that supplied out_data.
- out_ready  in  1  downstream accept; transfer on out_valid & out_ready.
- stat_sel  in  2  selects the counter shown on stat_cnt.
- stat_clr  in  1  synchronous clear of all grant counters.
- stat_cnt  out  CNT_W  grant count of requester stat_sel.

## Operation

- States: IDLE (output register empty) and HOLD (output register full).
- Priority pointer last_src, 2 bits, reset 3, so requester 0 has highest priority after reset.
- Search order: last_src+1, +2, +3, +4, modulo 4; the first asserted req wins.
- Capture condition: (state IDLE) or (state HOLD and out_ready). On capture with any req bit high:
  - gnt = winner (one-hot);
  - out_data <= req_data of the winner through the mux select;
  - out_src <= winner index; last_src <= winner.
- IDLE + any req -> HOLD. IDLE + no req -> IDLE, gnt = 0.
- HOLD + out_ready + any req -> HOLD, with a back-to-back capture and no bubble.
- HOLD + out_ready + no req -> IDLE.
- HOLD + !out_ready -> HOLD. gnt = 0; out_data and out_src are frozen.
- A req bit dropped before it is granted is simply skipped. There is no request latching.
- Reset values: state IDLE, out_valid 0, out_data 0, out_src 0, last_src 3, all counters 0. gnt is 0 while rst_n is low.
- Reset asserted mid-transfer discards the held word. No grant is issued until the first edge after rst_n deasserts.

## Timing

- Request-to-grant latency: 0 cycles. gnt is combinational from req, state, out_ready and last_src.
- Grant-to-output latency: 1 cycle. out_valid and out_data update on the edge where req & gnt is high.
- Throughput: one word per cycle while out_ready stays high and requests are pending.
- With all four requests held high, grants rotate 0,1,2,3,0,… with no starvation. Maximum wait is 3 grants.

## Configuration

- MUX_RR_ARBITER_STATS_EN defined:
  - four CNT_W-bit counters, each incremented on every grant to its requester;
  - counters saturate at all-ones;
  - stat_clr has priority over increment;
  - stat_cnt is a combinational read of counter[stat_sel].
- Not defined: counters are not instantiated, stat_cnt is tied to 0, and stat_sel and stat_clr are ignored.

## Structure

- Shared package mux_arb_pkg:
  - NUM_REQ = 4 and SRC_W = 2;
  - state enum (IDLE, HOLD);
  - reset constant for last_src (3).
- Sub-module mux4_sel: a purely combinational 4:1 DATA_W mux indexed by a 2-bit select. The arbiter instantiates it with the winner index as select.

## Test plan

- Reset then single request: req=4'b0001, req_data0=0xA, out_ready=1.
  - Required: gnt=0001 in the same cycle; next cycle out_valid=1, out_data=0xA, out_src=0.
- Rotation with all requests held: req=4'b1111, data 0xA/0xB/0xD/0xE on requesters 0..3, out_ready=1.
  - Required: out_data sequence 0xA,0xB,0xD,0xE,0xA on consecutive cycles; out_src 0,1,2,3,0.
- Backpressure: capture 0x1 from req0, then out_ready=0 for 3 cycles while req=4'b0010 with data 0x2.
  - Required: out_data stays 0x1 and gnt=0 during those cycles.
  - Required: the cycle out_ready=1, gnt=0010; 0x2 appears the following cycle.
- Fairness after skip: last_src=1, req=4'b1001.
  - Required: requester 3 is granted first (0x4), then requester 0 (0x1).
- Reset mid-operation: assert rst_n=0 while out_valid=1 and out_data=0x7.
  - Required: out_valid=0, out_data=0 immediately.
  - Required: after release with req=4'b1111, the first grant is requester 0.
- Statistics (macro defined): 300 grants to requester 2.
  - Required: stat_sel=2 reads 255 (saturated).
  - Required: pulse stat_clr, then stat_cnt reads 0; without the macro, stat_cnt is always 0.
